// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit frame controller.
package uart_tx_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic IDLE_BIT  = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and data-bit counter for the UART transmitter.
// ser_bit is the next data bit (LSB first); last_bit flags the final DATA cycle.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  shift,
   input  logic                  count,
   output logic                  ser_bit,
   output logic                  last_bit
);
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]      bit_cnt;

   assign ser_bit  = shift_reg[0];
   assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else begin
         if (load) begin
            shift_reg <= load_data;
         end else if (shift) begin
            shift_reg <= shift_reg >> 1;
         end
         // counts cycles spent in DATA; wraps on the last one so it leaves DATA at zero
         if (load) begin
            bit_cnt <= '0;
         end else if (count) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start, data (LSB first), optional parity, stop.
// Define UART_TX_B2B_EN to allow a new frame to be accepted during the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for DATA_VALID
// START  | start bit on the line
// DATA   | data bits, one per clock, LSB first
// PARITY | parity bit from the calculator
// STOP   | stop bit on the line
module uart_tx_frame_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PARITY_BIT,
   output logic                  PAR_CALC_EN,
   output logic                  TX_OUT,
   output logic                  BUSY
);
   state_t state, next_state;
   logic   accept;
   logic   par_en_q;
   logic   ser_bit, last_bit;
   logic   tx_next, busy_next;

   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
      .CLK       (CLK),
      .RST       (RST),
      .load      (accept),
      .load_data (P_DATA),
      .shift     (next_state == DATA),
      .count     (state == DATA),
      .ser_bit   (ser_bit),
      .last_bit  (last_bit)
   );

   assign PAR_CALC_EN = accept;

   always_comb begin
      accept = 1'b0;
      if (RST && DATA_VALID) begin
         if (state == IDLE) accept = 1'b1;
`ifdef UART_TX_B2B_EN
         if (state == STOP) accept = 1'b1;
`endif
      end

      next_state = state;
      unique case (state)
         IDLE:    next_state = accept ? START : IDLE;
         START:   next_state = DATA;
         DATA:    if (last_bit) next_state = par_en_q ? PARITY : STOP;
         PARITY:  next_state = STOP;
         STOP:    next_state = accept ? START : IDLE;
         default: next_state = IDLE;
      endcase

      // line outputs are registered from the state being entered
      tx_next   = IDLE_BIT;
      busy_next = 1'b1;
      unique case (next_state)
         IDLE:    busy_next = 1'b0;
         START:   tx_next   = START_BIT;
         DATA:    tx_next   = ser_bit;
         PARITY:  tx_next   = PARITY_BIT;
         STOP:    tx_next   = STOP_BIT;
         default: busy_next = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= IDLE;
         TX_OUT   <= IDLE_BIT;
         BUSY     <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state  <= next_state;
         TX_OUT <= tx_next;
         BUSY   <= busy_next;
         if (accept) par_en_q <= PAR_EN;
      end
   end
endmodule
